// File: rtl/frame_swap_ctrl_pkg.sv
// Shared definitions for the LED framebuffer swap controller: FSM state
// encoding and default parameter values.
package frame_swap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_WR    = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_SWAP       = 2'd3
    } swap_state_e;

    localparam int unsigned WR_TIMEOUT_DEFAULT     = 4096;
    localparam int unsigned CTRL_REG_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/frame_swap_ctrl.sv
// Double-buffer swap controller: holds off the AXI writer, waits for the
// driver to finish a frame, then flips the read/write buffer indices.
module frame_swap_ctrl
    import frame_swap_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_REG_WIDTH = CTRL_REG_WIDTH_DEFAULT,
    parameter int unsigned WR_TIMEOUT     = WR_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_en,
    input  logic                      swap_req,
    input  logic                      frame_end,
    input  logic                      wr_busy,
    output logic                      r_buffer,
    output logic                      w_buffer,
    output logic                      wr_hold,
    output logic                      swap_pending,
    output logic                      swap_done,
    output logic [CTRL_REG_WIDTH-1:0] frame_count,
    output logic [CTRL_REG_WIDTH-1:0] swap_count,
    output logic                      err_timeout
);

    localparam int unsigned      CNT_W     = $clog2(WR_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WR_TIMEOUT - 1);

    swap_state_e               state_q, state_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                      r_buffer_q, r_buffer_d;
    logic                      swap_done_q, swap_done_d;
    logic [CTRL_REG_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [CTRL_REG_WIDTH-1:0] swap_count_q, swap_count_d;
    logic                      err_timeout_q, err_timeout_d;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register so all state
        // updates see the pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            r_buffer_q    <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_count_q <= '0;
            swap_count_q  <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            r_buffer_q    <= r_buffer_d;
            swap_done_q   <= swap_done_d;
            frame_count_q <= frame_count_d;
            swap_count_q  <= swap_count_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        state_d       = state_q;
        wait_cnt_d    = '0;
        r_buffer_d    = r_buffer_q;
        swap_done_d   = 1'b0;
        swap_count_d  = swap_count_q;
        err_timeout_d = err_timeout_q;
        frame_count_d = frame_end ? frame_count_q + CTRL_REG_WIDTH'(1) : frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (swap_req) state_d = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                // frame_end is ignored here so a frame already in flight
                // never triggers the swap; the next full frame is awaited.
                if (!wr_busy) begin
                    state_d = ST_WAIT_FRAME;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_WAIT_FRAME;
                    err_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_end || !ctrl_en) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                r_buffer_d   = ~r_buffer_q;
                swap_done_d  = 1'b1;
                swap_count_d = swap_count_q + CTRL_REG_WIDTH'(1);
                state_d      = swap_req ? ST_WAIT_WR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign r_buffer     = r_buffer_q;
    assign w_buffer     = ~r_buffer_q;
    assign wr_hold      = (state_q != ST_IDLE);
    assign swap_pending = (state_q != ST_IDLE);
    assign swap_done    = swap_done_q;
    assign frame_count  = frame_count_q;
    assign swap_count   = swap_count_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: doc/frame_swap_ctrl.md
FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 SHALL have parameter CTRL_REG_WIDTH, default 32, width of count outputs.
REQ-002 SHALL have parameter WR_TIMEOUT, default 4096, max cycles to wait for writer idle.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ctrl_en, input, 1, display enabled (led_driver running).
REQ-007 SHALL have port swap_req, input, 1, one-cycle pulse from host requesting buffer swap.
REQ-008 SHALL have port frame_end, input, 1, one-cycle pulse from driver after last bitplane of last row.
REQ-009 SHALL have port wr_busy, input, 1, level; AXI write burst to framebuffer in progress.
REQ-010 SHALL have port r_buffer, output, 1, buffer index read by driver.
REQ-011 SHALL have port w_buffer, output, 1, buffer index written by AXI; always ~r_buffer.
REQ-012 SHALL have port wr_hold, output, 1, level; writer must not start a new burst.
REQ-013 SHALL have port swap_pending, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port swap_done, output, 1, one-cycle pulse on cycle r_buffer toggles.
REQ-015 SHALL have port frame_count, output, CTRL_REG_WIDTH, frames displayed, wraps.
REQ-016 SHALL have port swap_count, output, CTRL_REG_WIDTH, swaps performed, wraps.
REQ-017 SHALL have port err_timeout, output, 1, sticky, writer-idle wait timed out.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_WR, WAIT_FRAME, SWAP.
REQ-019 IDLE: swap_req -> WAIT_WR next cycle; otherwise stay.
REQ-020 WAIT_WR: wr_hold=1; wr_busy=0 -> WAIT_FRAME; wait counter reaching WR_TIMEOUT-1 with wr_busy=1 -> WAIT_FRAME and set err_timeout.
REQ-021 WAIT_FRAME: wr_hold=1; frame_end=1 or ctrl_en=0 -> SWAP.
REQ-022 SWAP: one cycle; r_buffer toggles at end of this cycle, swap_done=1, swap_count+1, wr_hold=1; next state IDLE, or WAIT_WR if swap_req=1 this cycle.
REQ-023 swap_req in WAIT_WR or WAIT_FRAME SHALL be coalesced (no extra swap queued).
REQ-024 wr_hold SHALL be 0 in IDLE; wait counter SHALL clear on entry to WAIT_WR.
REQ-025 frame_count SHALL increment on every frame_end regardless of state or ctrl_en.
REQ-026 frame_end coincident with WAIT_WR exit SHALL NOT trigger a swap; the next frame_end is awaited.
REQ-027 Latency: frame_end in WAIT_FRAME at cycle N -> SWAP at N+1 -> r_buffer new value visible at N+2.
REQ-028 r_buffer SHALL change only via SWAP; all outputs registered except w_buffer, swap_pending and wr_hold (decoded from registered state).
REQ-029 Counters SHALL wrap modulo 2^CTRL_REG_WIDTH; wait counter width $clog2(WR_TIMEOUT)+1.

Reset
REQ-030 rst SHALL force state IDLE, r_buffer=0 (w_buffer=1), wr_hold=0, swap_done=0, frame_count=0, swap_count=0, err_timeout=0, wait counter=0.
REQ-031 rst mid-operation SHALL abandon any pending swap; no swap_done pulse issued.
REQ-032 rst SHALL take priority over all simultaneous inputs.

Structure
REQ-033 State encoding and WR_TIMEOUT default SHALL live in the shared led package.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 Reset, then swap_req with wr_busy=0, ctrl_en=1, frame_end 10 cycles later -> r_buffer 0->1 two cycles after frame_end, swap_done one pulse, swap_count=1.
REQ-036 swap_req while wr_busy=1 for 20 cycles -> wr_hold=1 throughout, state stays WAIT_WR until wr_busy drops, then swap on next frame_end.
REQ-037 wr_busy stuck high, WR_TIMEOUT=16 -> WAIT_FRAME entered after 16 cycles, err_timeout=1 and stays 1 after swap.
REQ-038 Three swap_req pulses during WAIT_FRAME -> exactly one swap, swap_count=1; swap_req during SWAP -> second swap on following frame.
REQ-039 ctrl_en=0 in WAIT_FRAME with no frame_end -> swap within 2 cycles; 5 frame_end pulses in IDLE -> frame_count=5, r_buffer unchanged.
REQ-040 rst asserted in WAIT_FRAME -> r_buffer=0, wr_hold=0, counts 0; subsequent frame_end causes no swap.
